// File: rtl/noc_sched_pkg.sv
// Shared types and helpers for the per-output packet scheduler.
// Holds the port count, port index type, FSM state encoding and the round-robin picker.
// Pure declarations: no latency, no backpressure.
package noc_sched_pkg;

    localparam int NPORTS = 5;
    localparam int PW     = 3;

    typedef logic [PW-1:0] port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    // First set bit of req at or after ptr, wrapping; one-hot result, all-zero if no request.
    function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                                  input port_idx_t         ptr);
        logic [NPORTS-1:0] pick;
        int                idx;
        pick = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NPORTS;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic port_idx_t oh_to_idx(input logic [NPORTS-1:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (oh[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_port_sched_slice.sv
// One output's wormhole arbiter: round-robin pick when idle, locked to the owner mid-packet.
// Zero-cycle grant (request to select is combinational); state updates on the following edge.
// Backpressure: no grant unless the downstream has room (credit counter or ready, per OPS_CREDIT_EN).
module output_port_sched_slice
    import noc_sched_pkg::*;
`ifdef OPS_CREDIT_EN
#(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
)
`endif
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NPORTS-1:0] i_req,
    input  logic [NPORTS-1:0] i_tail,
`ifdef OPS_CREDIT_EN
    input  logic              i_credit_ret,
    output logic              o_credit_ovf,
`else
    input  logic              i_ready,
`endif
    output logic              o_vld,
    output logic [NPORTS-1:0] o_sel
);

    sched_state_t      r_state;
    port_idx_t         r_owner;
    port_idx_t         r_ptr;

    logic [NPORTS-1:0] w_owner_oh;
    logic [NPORTS-1:0] w_pick;
    logic              w_avail;
    logic              w_go;
    logic              w_tail;
    port_idx_t         w_win;
    port_idx_t         w_ptr_nxt;

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
        if (r_state == LOCKED) w_pick = i_req & w_owner_oh;
        else                   w_pick = rr_pick(i_req, r_ptr);
    end

    // Gating on RST_N keeps the crossbar quiet for the whole reset window.
    assign w_go      = RST_N & w_avail & (|w_pick);
    assign o_vld     = w_go;
    assign o_sel     = w_go ? w_pick : '0;
    assign w_tail    = |(w_pick & i_tail);
    assign w_win     = oh_to_idx(w_pick);
    assign w_ptr_nxt = (w_win == port_idx_t'(NPORTS - 1)) ? '0 : port_idx_t'(w_win + port_idx_t'(1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_go) begin
            if (w_tail) begin
                r_state <= IDLE;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_state <= LOCKED;
                r_owner <= w_win;
            end
        end
    end

`ifdef OPS_CREDIT_EN
    logic [CW-1:0] r_credits;
    logic          r_ovf;

    assign w_avail      = (r_credits != '0);
    assign o_credit_ovf = r_ovf;

    // A return landing while a flit leaves cancels out, so it can never overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_credits <= CW'(CREDITS);
            r_ovf     <= 1'b0;
        end else begin
            case ({w_go, i_credit_ret})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01: begin
                    if (r_credits == CW'(CREDITS)) r_ovf     <= 1'b1;
                    else                           r_credits <= r_credits + CW'(1);
                end
                default: ;
            endcase
        end
    end
`else
    assign w_avail = i_ready;
`endif

endmodule

// File: rtl/output_port_scheduler.sv
// Packet-aware per-output scheduler for the mesh router; OPS_CREDIT_EN selects credit vs ready flow control.
// Zero-cycle arbitration: in_valid/in_dest/in_tail to out_sel/out_valid/in_grant in the same cycle.
// Backpressure: an output grants nothing while its downstream has no credit (or out_ready is low).
module output_port_scheduler #(
    parameter int NPORTS  = noc_sched_pkg::NPORTS,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*NPORTS-1:0] in_dest,
    input  logic [NPORTS-1:0]        in_tail,
    output logic [NPORTS-1:0]        in_grant,
    output logic [NPORTS-1:0]        out_valid,
    output logic [NPORTS*NPORTS-1:0] out_sel,
`ifdef OPS_CREDIT_EN
    input  logic [NPORTS-1:0]        out_credit_ret,
    output logic                     err_credit_ovf
`else
    input  logic [NPORTS-1:0]        out_ready
`endif
);

    if (CREDITS < 1 || CW < $clog2(CREDITS + 1)) begin : g_cfg_err
        $error("output_port_scheduler: credit counter too narrow for CREDITS");
    end

`ifdef OPS_CREDIT_EN
    logic [NPORTS-1:0] w_ovf;
    assign err_credit_ovf = |w_ovf;
`endif

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [NPORTS-1:0] w_req;

        // Transpose: bit i of w_req is input i asking for this output.
        always_comb begin
            w_req = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_req[i] = in_valid[i] & in_dest[i*NPORTS + o];
            end
        end

        output_port_sched_slice
`ifdef OPS_CREDIT_EN
        #(
            .CREDITS (CREDITS),
            .CW      (CW)
        )
`endif
        u_slice (
            .CLK          (CLK),
            .RST_N        (RST_N),
            .i_req        (w_req),
            .i_tail       (in_tail),
`ifdef OPS_CREDIT_EN
            .i_credit_ret (out_credit_ret[o]),
            .o_credit_ovf (w_ovf[o]),
`else
            .i_ready      (out_ready[o]),
`endif
            .o_vld        (out_valid[o]),
            .o_sel        (out_sel[o*NPORTS +: NPORTS])
        );
    end

    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NPORTS; o++) begin
            in_grant = in_grant | out_sel[o*NPORTS +: NPORTS];
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_dest_chk
        a_dest_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
            in_valid[i] |-> $onehot0(in_dest[i*NPORTS +: NPORTS]));
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Scoreboarded bench for output_port_scheduler; credit scenarios run when OPS_CREDIT_EN is defined.
module tb_output_port_scheduler;

    localparam int NP = 5;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NP-1:0]    in_valid = '0;
    logic [NP*NP-1:0] in_dest = '0;
    logic [NP-1:0]    in_tail = '0;
    logic [NP-1:0]    in_grant;
    logic [NP-1:0]    out_valid;
    logic [NP*NP-1:0] out_sel;
`ifdef OPS_CREDIT_EN
    logic [NP-1:0]    out_credit_ret = '0;
    logic             err_credit_ovf;
    bit               auto_ret = 1'b1;
`else
    logic [NP-1:0]    out_ready = '0;
`endif

    always #5 CLK = ~CLK;

    output_port_scheduler #(.NPORTS(NP), .CREDITS(4)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .in_valid       (in_valid),
        .in_dest        (in_dest),
        .in_tail        (in_tail),
        .in_grant       (in_grant),
        .out_valid      (out_valid),
        .out_sel        (out_sel),
`ifdef OPS_CREDIT_EN
        .out_credit_ret (out_credit_ret),
        .err_credit_ovf (err_credit_ovf)
`else
        .out_ready      (out_ready)
`endif
    );

    typedef struct {
        string            tag;
        logic [NP-1:0]    g;
        logic [NP-1:0]    ov;
        logic [NP*NP-1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   dst[NP];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_dst(input int d0, input int d1, input int d2, input int d3, input int d4);
        dst[0] = d0; dst[1] = d1; dst[2] = d2; dst[3] = d3; dst[4] = d4;
    endtask

    // One cycle: drive after the rising edge, expect grants g, compare on the falling edge.
    // rr is out_ready, or the explicit credit-return vector when auto_ret is off.
    task automatic step(input string tag, input logic rst, input logic [NP-1:0] v,
                        input logic [NP-1:0] tl, input logic [NP-1:0] rr, input logic [NP-1:0] g);
        exp_t          e;
        logic [NP-1:0] oh;
        @(posedge CLK);
        #1;
        RST_N    = rst;
        in_valid = v;
        in_tail  = tl;
        e.tag = tag;
        e.g   = g;
        e.ov  = '0;
        e.sel = '0;
        for (int i = 0; i < NP; i++) begin
            oh          = '0;
            oh[dst[i]]  = 1'b1;
            in_dest[i*NP +: NP] = v[i] ? oh : '0;
            if (g[i]) begin
                e.ov[dst[i]]         = 1'b1;
                e.sel[dst[i]*NP + i] = 1'b1;
            end
        end
`ifdef OPS_CREDIT_EN
        out_credit_ret = auto_ret ? e.ov : rr;
`else
        out_ready = rr;
`endif
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        chk({e.tag, ":in_grant"},  32'(in_grant),  32'(e.g));
        chk({e.tag, ":out_valid"}, 32'(out_valid), 32'(e.ov));
        chk({e.tag, ":out_sel"},   32'(out_sel),   32'(e.sel));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests present during reset must not be granted.
        set_dst(2, 0, 0, 2, 0);
        step("reset", 1'b0, 5'b01001, 5'b11111, 5'b11111, 5'b00000);

        // Two single-flit streams into output 2 alternate.
        step("rr_a", 1'b1, 5'b01001, 5'b11111, 5'b11111, 5'b00001);
        step("rr_b", 1'b1, 5'b01001, 5'b11111, 5'b11111, 5'b01000);
        step("rr_c", 1'b1, 5'b01001, 5'b11111, 5'b11111, 5'b00001);
        step("rr_d", 1'b1, 5'b01001, 5'b11111, 5'b11111, 5'b01000);

        // Wormhole lock on output 4.
        set_dst(0, 4, 4, 4, 4);
        step("wh_head",  1'b1, 5'b00010, 5'b00000, 5'b11111, 5'b00010);
        step("wh_body",  1'b1, 5'b00110, 5'b00100, 5'b11111, 5'b00010);
        step("wh_tail",  1'b1, 5'b00110, 5'b00110, 5'b11111, 5'b00010);
        step("wh_next",  1'b1, 5'b00100, 5'b00100, 5'b11111, 5'b00100);
        step("lk_head",  1'b1, 5'b10000, 5'b00000, 5'b11111, 5'b10000);
        step("lk_hold",  1'b1, 5'b11000, 5'b01000, 5'b11111, 5'b10000);
        step("lk_tail",  1'b1, 5'b11000, 5'b11000, 5'b11111, 5'b10000);
        step("lk_after", 1'b1, 5'b01000, 5'b01000, 5'b11111, 5'b01000);

`ifndef OPS_CREDIT_EN
        // Downstream not ready stalls only that output.
        set_dst(0, 0, 1, 0, 0);
        step("bp_stall",   1'b1, 5'b00100, 5'b00100, 5'b11101, 5'b00000);
        step("bp_release", 1'b1, 5'b00100, 5'b00100, 5'b11111, 5'b00100);
`endif

        // Reset while output 3 is locked on input 4 drops the lock.
        set_dst(0, 3, 0, 0, 3);
        step("mid_head",  1'b1, 5'b10000, 5'b00000, 5'b11111, 5'b10000);
        step("mid_rst",   1'b0, 5'b10000, 5'b00000, 5'b11111, 5'b00000);
        step("mid_after", 1'b1, 5'b10010, 5'b00010, 5'b11111, 5'b00010);

        // All inputs to distinct outputs in one cycle.
        set_dst(1, 2, 3, 4, 0);
        step("all_five", 1'b1, 5'b11111, 5'b11111, 5'b11111, 5'b11111);

`ifdef OPS_CREDIT_EN
        auto_ret = 1'b0;
        set_dst(0, 0, 0, 0, 0);
        step("cr_rst", 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("err_at_reset", 32'(err_credit_ovf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step("cr_xfer", 1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
        end
        step("cr_empty",  1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
        step("cr_ret",    1'b1, 5'b00001, 5'b00001, 5'b00001, 5'b00000);
        step("cr_reuse",  1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
        step("cr_empty2", 1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
        chk("err_no_ovf", 32'(err_credit_ovf), 32'd0);

        step("ovf_rst",   1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        step("ovf_pulse", 1'b1, 5'b00000, 5'b00000, 5'b00001, 5'b00000);
        step("ovf_next",  1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("err_set", 32'(err_credit_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step("ovf_xfer", 1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
        end
        step("ovf_empty", 1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
        chk("err_sticky", 32'(err_credit_ovf), 32'd1);
        step("ovf_clear", 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("err_cleared", 32'(err_credit_ovf), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Sequential, packet-aware replacement for the combinational per-output priority arbiter in the 5-port mesh router. For each output port it picks one requesting input with a round-robin pointer and holds that grant until the packet's tail flit has transferred (wormhole lock). It also gates each transfer on downstream buffer availability. It sits between the route-compute stage (per-input destination one-hot) and the crossbar (per-output input-select one-hot).

## Interface
Parameters:
- NPORTS, 5, number of router inputs and outputs.
- CREDITS, 4, downstream buffer depth per output; sets the credit counter reset value.
- CW, $clog2(CREDITS+1), credit counter width.

Ports:
- CLK  in  1  router clock; the only clock.
- RST_N  in  1  reset; asynchronous and active-low.
- in_valid  in  NPORTS  input i presents a flit.
- in_dest  in  NPORTS*NPORTS  per-input one-hot requested output, slice [i*NPORTS +: NPORTS]; upstream holds it stable for the whole packet.
- in_tail  in  NPORTS  the presented flit is a tail; head+tail together means a single-flit packet.
- in_grant  out  NPORTS  the flit on input i transfers this cycle.
- out_valid  out  NPORTS  output o transfers a flit this cycle.
- out_sel  out  NPORTS*NPORTS  per-output one-hot input select to the crossbar, slice [o*NPORTS +: NPORTS]; all-zero when out_valid[o]=0.
- out_credit_ret  in  NPORTS  downstream freed one slot (only with OPS_CREDIT_EN).
- out_ready  in  NPORTS  downstream accepts this cycle (only without OPS_CREDIT_EN).
- err_credit_ovf  out  1  sticky error flag: credit returned while the counter is full (only with OPS_CREDIT_EN).

## Operation
- Per-output state machine with two states, IDLE and LOCKED. Registered state per output: state, owner[2:0], ptr[2:0], credits[CW-1:0].
- Candidate set for output o: inputs i with in_valid[i] & in_dest[i][o].
- IDLE:
  - Winner is the first candidate searched from ptr upward, modulo NPORTS.
  - Transfer happens if a winner exists and avail[o] is true.
  - avail[o] is credits>0 with OPS_CREDIT_EN, and out_ready[o] without it.
- Transfer of a non-tail flit in IDLE: go to LOCKED, set owner=winner.
- Transfer of a tail flit, in IDLE (single-flit packet) or in LOCKED: ptr=(winner+1) mod NPORTS and the state becomes or stays IDLE.
- LOCKED: only the owner is eligible, and only when in_valid[owner] & in_dest[owner][o]; other requests wait. Non-tail transfers keep the lock.
- No transfer in a cycle: ptr and state are unchanged.
- in_grant[i] is the OR over o of out_sel[o][i]. Because in_dest is one-hot, at most one output grants an input.
- Credits:
  - Decrement on transfer; increment on out_credit_ret.
  - Transfer and credit return in the same cycle: counter unchanged.
  - Return at CREDITS: counter holds and err_credit_ovf sets. It clears only on reset.
- in_dest with more than one bit set is illegal; the behaviour is undefined, and an assertion flags it.

## Timing
- Grant path is combinational: in_valid/in_dest/in_tail to out_sel/out_valid/in_grant in the same cycle, so the transfer happens in the cycle the request is presented. This is zero-cycle arbitration latency.
- State, ptr, owner and credits update on the rising CLK edge after the transfer.
- Credit returned in cycle t is usable in cycle t+1.
- Reset values:
  - state=IDLE, ptr=0, owner=0, credits=CREDITS, err_credit_ovf=0.
  - While RST_N=0, out_valid, out_sel and in_grant are forced 0.
- Reset mid-packet drops all locks immediately. The next head is arbitrated from ptr=0.
- Throughput is one flit per output per cycle. Outputs arbitrate independently and concurrently.

## Configuration
- OPS_CREDIT_EN defined: credit counters, out_credit_ret and err_credit_ovf exist, and avail[o] is credits>0. out_ready is absent.
- OPS_CREDIT_EN undefined: no counters, and avail[o] is out_ready[o]. out_credit_ret and err_credit_ovf are absent.

## Structure
- Package noc_sched_pkg holds:
  - NPORTS and the port index typedef;
  - the sched_state_t enum {IDLE, LOCKED};
  - the rr_pick function (request vector, pointer) returning a one-hot result.
- Sub-module output_port_sched_slice contains one output's FSM, pointer, owner and credit counter. The top instantiates NPORTS slices, transposes in_dest into per-output request vectors, and ORs the per-output selects into in_grant.

## Test plan
- Reset, then inputs 0 and 3 each send a single-flit packet to output 2 every cycle, avail high -> grants alternate 0,3,0,3; ptr ends at 1 then 4.
- Input 1 sends a 3-flit packet to output 4 while input 2 requests output 4 from cycle 1 -> input 1 gets three consecutive grants; input 2 is granted the cycle after input 1's tail.
- OPS_CREDIT_EN, CREDITS=4, no credit returns, continuous flits to output 0 -> exactly 4 transfers, then out_valid[0]=0. One out_credit_ret gives exactly one more transfer the next cycle.
- out_credit_ret pulsed with credits=4 -> err_credit_ovf=1 from the next cycle and stays 1 until reset; credits stays 4.
- RST_N asserted mid-packet while output 3 is LOCKED on input 4 -> out_valid=0 during reset. After release, a new head from input 1 is granted even though input 4 is still valid with a body flit.
- All five inputs target five distinct outputs in the same cycle -> all five in_grant bits high in that cycle, each out_sel one-hot on the matching input.
